// File: rtl/board_issuer.sv
// board_issuer: producer side of the board/board_valid -> attacked/attacked_valid
// handshake. It assembles a position from single-square host writes. On commit it
// issues that position to an attack evaluator and freezes the board until the
// evaluator answers or the wait times out. The answer is returned to the host as a
// one-cycle result strobe.

`ifndef EMPTY_POSN
`define EMPTY_POSN   4'h0
`define WHITE_PAWN   4'h1
`define WHITE_KNIGHT 4'h2
`define WHITE_BISHOP 4'h3
`define WHITE_ROOK   4'h4
`define WHITE_QUEEN  4'h5
`define WHITE_KING   4'h6
`define BLACK_PAWN   4'h9
`define BLACK_KNIGHT 4'hA
`define BLACK_BISHOP 4'hB
`define BLACK_ROOK   4'hC
`define BLACK_QUEEN  4'hD
`define BLACK_KING   4'hE
`endif

module board_issuer #(
   parameter int PIECE_WIDTH    = 4,
   parameter int SIDE_WIDTH     = PIECE_WIDTH * 8,
   parameter int BOARD_WIDTH    = SIDE_WIDTH * 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   wr_en,
   input  logic [2:0]             wr_row,
   input  logic [2:0]             wr_col,
   input  logic [PIECE_WIDTH-1:0] wr_piece,
   input  logic                   commit,
   output logic                   busy,
   output logic                   wr_err,
   output logic [BOARD_WIDTH-1:0] board,
   output logic                   board_valid,
   input  logic                   attacked_in,
   input  logic                   attacked_valid,
   output logic                   result,
   output logic                   result_valid,
   output logic                   timeout
);

   // Reject a timeout that the 16-bit wait counter cannot represent, or one too short
   // to leave a real wait window.
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("board_issuer: TIMEOUT_CYCLES must be in 2..65535");
   end

   localparam int CNT_W = 16;
   localparam int IDX_W = $clog2(BOARD_WIDTH);

   // Code of an empty square at the configured piece width.
   localparam logic [PIECE_WIDTH-1:0] EMPTY_CODE = PIECE_WIDTH'(`EMPTY_POSN);

   // An empty position is the empty square code repeated across all 64 squares.
   localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD = {(BOARD_WIDTH / PIECE_WIDTH){EMPTY_CODE}};

   // Last counter value in WAIT before the evaluation gives up.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   // Handshake states.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]             state_q,   state_d;
   logic [BOARD_WIDTH-1:0] board_q,   board_d;
   logic [CNT_W-1:0]       cnt_q,     cnt_d;
   logic                   result_q,  result_d;
   logic                   timeout_q, timeout_d;
   logic [IDX_W-1:0]       wr_idx;

   // Bit offset of the square addressed by the host write.
   always_comb begin
      wr_idx = IDX_W'(IDX_W'(wr_row) * IDX_W'(SIDE_WIDTH)
                    + IDX_W'(wr_col) * IDX_W'(PIECE_WIDTH));
   end

   // Next-state logic: board edits in IDLE, the issue/wait/done sequence otherwise.
   always_comb begin
      // NOTE: every variable gets a hold-value default first, so paths that do not
      // assign it keep the register value instead of inferring a latch.
      state_d   = state_q;
      board_d   = board_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      timeout_d = timeout_q;

      case (state_q)
         S_IDLE: begin
            // Clear is applied before the write, so clear+write leaves one piece.
            if (clear) begin
               board_d = EMPTY_BOARD;
            end
            if (wr_en) begin
               board_d[wr_idx +: PIECE_WIDTH] = wr_piece;
            end
            // Edits in the commit cycle are part of the issued position.
            if (commit) begin
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // An answer on the expiry cycle takes priority over the timeout.
            if (attacked_valid) begin
               result_d  = attacked_in;
               timeout_d = 1'b0;
               state_d   = S_DONE;
            end else if (cnt_q == LAST_CNT) begin
               result_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any evaluation in flight and empties the board.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         // NOTE: the board storage is reset on purpose: after reset the position
         // presented downstream must be all empty squares, not power-up garbage.
         board_q   <= EMPTY_BOARD;
         cnt_q     <= '0;
         result_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         // NOTE: registers are updated with non-blocking assignments so every
         // register sees the pre-edge values of the others.
         state_q   <= state_d;
         board_q   <= board_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         timeout_q <= timeout_d;
      end
   end

   // Outputs decoded from state; wr_err flags host requests dropped while busy.
   always_comb begin
      busy         = (state_q != S_IDLE);
      board_valid  = (state_q == S_ISSUE);
      result_valid = (state_q == S_DONE);
      wr_err       = (state_q != S_IDLE) && (wr_en || clear || commit);
      board        = board_q;
      result       = result_q;
      timeout      = timeout_q;
   end

endmodule

// File: tb/tb_board_issuer.sv
// Testbench for board_issuer: directed stimulus feeds a scoreboard of expected boards
// and results; a negedge monitor compares them whenever the DUT strobes an output.

`timescale 1ns/1ps

`ifndef EMPTY_POSN
`define EMPTY_POSN   4'h0
`define WHITE_PAWN   4'h1
`define WHITE_KNIGHT 4'h2
`define WHITE_BISHOP 4'h3
`define WHITE_ROOK   4'h4
`define WHITE_QUEEN  4'h5
`define WHITE_KING   4'h6
`define BLACK_PAWN   4'h9
`define BLACK_KNIGHT 4'hA
`define BLACK_BISHOP 4'hB
`define BLACK_ROOK   4'hC
`define BLACK_QUEEN  4'hD
`define BLACK_KING   4'hE
`endif

module tb_board_issuer;

   localparam int TO = 64;

   typedef struct packed {
      logic res;
      logic to;
      int   lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         clear;
   logic         wr_en;
   logic [2:0]   wr_row;
   logic [2:0]   wr_col;
   logic [3:0]   wr_piece;
   logic         commit;
   logic         busy;
   logic         wr_err;
   logic [255:0] board;
   logic         board_valid;
   logic         attacked_in;
   logic         attacked_valid;
   logic         result;
   logic         result_valid;
   logic         timeout;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int bv_cyc = 0;

   logic [255:0] mdl;
   logic [255:0] empty_b;
   logic [255:0] brd_q[$];
   exp_t         res_q[$];

   board_issuer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en),
      .wr_row(wr_row), .wr_col(wr_col), .wr_piece(wr_piece), .commit(commit),
      .busy(busy), .wr_err(wr_err), .board(board), .board_valid(board_valid),
      .attacked_in(attacked_in), .attacked_valid(attacked_valid),
      .result(result), .result_valid(result_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare issued boards and returned results against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (board_valid) begin
         bv_cyc = cyc;
         if (brd_q.size() == 0) check("spurious_board_valid", board_valid, 1'b0);
         else check("issued_board", board, brd_q.pop_front());
      end
      if (result_valid) begin
         if (res_q.size() == 0) check("spurious_result_valid", result_valid, 1'b0);
         else begin
            e = res_q.pop_front();
            check("result", result, e.res);
            check("timeout", timeout, e.to);
            check("result_latency", cyc - bv_cyc, e.lat);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int r, input int c, input logic [3:0] p);
      mdl[r*32 + c*4 +: 4] = p;
   endtask

   task automatic do_write(input int r, input int c, input logic [3:0] p);
      wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_piece = p;
      tick();
      wr_en = 1'b0;
      put(r, c, p);
   endtask

   // Commit the model board; ends at the negedge of the board_valid cycle.
   task automatic issue(input logic push_res, input logic er, input logic et,
                        input int lat, input logic av_in_issue);
      exp_t e;
      brd_q.push_back(mdl);
      if (push_res) begin
         e.res = er; e.to = et; e.lat = lat;
         res_q.push_back(e);
      end
      commit = 1'b1;
      tick();
      commit = 1'b0;
      attacked_valid = av_in_issue;
      attacked_in = av_in_issue;
      @(negedge clk);
      check("commit_to_board_valid", board_valid, 1'b1);
   endtask

   // Called at a negedge: pulse the evaluator answer n cycles later.
   task automatic answer_in(input int n, input logic val);
      repeat (n) @(posedge clk);
      #1;
      attacked_valid = 1'b1; attacked_in = val;
      tick();
      attacked_valid = 1'b0; attacked_in = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200; i++) begin
         if (res_q.size() == 0 && !busy) break;
         tick();
      end
      check(name, res_q.size(), 0);
   endtask

   initial begin
      empty_b = {64{`EMPTY_POSN}};
      mdl = empty_b;
      reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0;
      wr_piece = '0; commit = 1'b0; attacked_in = 1'b0; attacked_valid = 1'b0;

      // 1: reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_board", board, empty_b);
      check("rst_busy", busy, 1'b0);
      check("rst_board_valid", board_valid, 1'b0);
      check("rst_result_valid", result_valid, 1'b0);
      check("rst_outputs", {wr_err, result, timeout}, 3'b000);
      tick();
      reset = 1'b0;
      tick();

      // 2: two pieces, evaluator answers attacked=1 three cycles after board_valid
      do_write(0, 0, `WHITE_ROOK);
      do_write(7, 7, `BLACK_KING);
      @(negedge clk);
      check("sq_0_0", board[3:0], `WHITE_ROOK);
      check("sq_7_7", board[255:252], `BLACK_KING);
      issue(1'b1, 1'b1, 1'b0, 4, 1'b0);
      answer_in(3, 1'b1);
      drain("drain_answer");
      check("result_hold", {result, timeout}, 2'b10);

      // 3: silent evaluator times out
      issue(1'b1, 1'b0, 1'b1, TO + 1, 1'b0);
      drain("drain_timeout");

      // 4: host requests during WAIT are dropped with wr_err
      issue(1'b1, 1'b0, 1'b0, 6, 1'b0);
      tick();
      wr_en = 1'b1; wr_row = 3'd3; wr_col = 3'd4; wr_piece = `BLACK_QUEEN;
      @(negedge clk);
      check("wr_err_wait", wr_err, 1'b1);
      tick();
      wr_en = 1'b0;
      @(negedge clk);
      check("wr_err_single", wr_err, 1'b0);
      check("board_frozen", board, mdl);
      answer_in(3, 1'b0);
      drain("drain_busy_write");
      check("result_after_drop", {result, timeout}, 2'b00);
      check("board_after_drop", board, mdl);

      // attacked_valid outside WAIT is ignored
      attacked_valid = 1'b1; attacked_in = 1'b1;
      tick(); tick();
      attacked_valid = 1'b0; attacked_in = 1'b0;
      @(negedge clk);
      check("idle_av_ignored", busy, 1'b0);

      // 5: clear with a same-cycle write leaves only that square
      clear = 1'b1;
      mdl = empty_b;
      do_write(2, 2, `WHITE_PAWN);
      clear = 1'b0;
      @(negedge clk);
      check("clear_and_write", board, mdl);
      // answer arrives on the expiry cycle: answer wins
      issue(1'b1, 1'b1, 1'b0, TO + 1, 1'b0);
      answer_in(TO, 1'b1);
      drain("drain_expiry_answer");

      // answer during ISSUE is ignored, so the wait times out
      issue(1'b1, 1'b0, 1'b1, TO + 1, 1'b1);
      tick();
      attacked_valid = 1'b0; attacked_in = 1'b0;
      drain("drain_issue_answer");

      // earliest answer: first WAIT cycle
      issue(1'b1, 1'b1, 1'b0, 2, 1'b0);
      answer_in(1, 1'b1);
      drain("drain_first_wait");

      // 6: reset during WAIT aborts the evaluation
      issue(1'b0, 1'b0, 1'b0, 0, 1'b0);
      tick(); tick();
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_board", board, empty_b);
      mdl = empty_b;
      tick();
      reset = 1'b0;
      repeat (TO + 10) tick();
      check("abort_no_result", res_q.size(), 0);
      check("abort_idle", busy, 1'b0);
      check("boards_consumed", brd_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
